uc_bridge: RTL and testbench

- Synchronous, parametrised successor to the strobe-clocked microcontroller interface.
- Synchronises the asynchronous microcontroller strobe into the FPGA clock domain and runs each data access as a request/acknowledge cycle on the internal microcontroller bus, with a timeout.
- Latches rising edges of NINT interrupt sources into read-to-clear pending bits.
- Sits between the microcontroller pins and the internal register bus that serves the QBus-side logic.

---
 rtl/uc_pkg.sv | 21 ++
 rtl/uc_sync.sv | 36 +++
 rtl/uc_bridge.sv | 155 +++++++++++++++
 tb/tb_uc_bridge.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the uc_bridge microcontroller interface: FSM states,
// timeout read-data fill and status-word layout.
package uc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    HOLD = 2'd2
  } uc_state_e;

  // Bit replicated across the whole data word when a read times out.
  localparam logic TIMEOUT_FILL = 1'b1;

  // Status word: pending interrupts from bit 0 upward, error flag in the MSB.
  localparam int unsigned STAT_PEND_LSB = 0;

  function automatic int unsigned stat_err_bit(input int unsigned data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/uc_sync.sv
// Two-flop synchroniser with a rising-edge output taken after the second flop.
module uc_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_sync,
  output logic [W-1:0] d_rise
);

  logic [W-1:0] s1_q, s2_q, s3_q;
  logic [W-1:0] s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = d_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign d_sync = s2_q;
  assign d_rise = s2_q & ~s3_q;

endmodule

// File: rtl/uc_bridge.sv
// Microcontroller pin interface to internal request/acknowledge register bus,
// with timeout and read-to-clear interrupt pending bits. UC_AUTOINC_EN: address auto-increment.
module uc_bridge
  import uc_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned NINT    = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] uc_data_in,
  output logic [DATA_W-1:0] uc_data_out,
  output logic              uc_data_oe,
  input  logic              uc_addr_set,
  input  logic              uc_write,
  input  logic              uc_strobe,
  output logic              uc_not_ready,
  output logic              uc_interrupt,
  output logic [ADDR_W-1:0] uADDR,
  output logic [DATA_W-1:0] uDATA_W,
  input  logic [DATA_W-1:0] uDATA_R,
  output logic              uWRITE,
  output logic              uREQ,
  input  logic              uACK,
  input  logic [NINT-1:0]   uINTERRUPT
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam int unsigned ERR_BIT = stat_err_bit(DATA_W);

  logic            stb_sync, stb_rise;
  logic [NINT-1:0] irq_sync, irq_rise;

  uc_sync #(.W(1)) u_stb_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_in    (uc_strobe),
    .d_sync  (stb_sync),
    .d_rise  (stb_rise)
  );

  uc_sync #(.W(NINT)) u_irq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_in    (uINTERRUPT),
    .d_sync  (irq_sync),
    .d_rise  (irq_rise)
  );

  uc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NINT-1:0]   pend_q, pend_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] status_w;

  always_comb begin
    status_w = '0;
    status_w[ERR_BIT] = err_q;
    status_w[STAT_PEND_LSB +: NINT] = pend_q;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q | irq_rise;
    err_d   = err_q;
    dout_d  = dout_q;
    req_d   = req_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (stb_rise) begin
          if (uc_addr_set) begin
            if (uc_write) begin
              addr_d = uc_data_in[ADDR_W-1:0];
            end else begin
              // Every pending bit is returned, so only edges from this clock survive.
              dout_d = status_w;
              pend_d = irq_rise;
              err_d  = 1'b0;
            end
            state_d = HOLD;
          end else begin
            req_d   = 1'b1;
            wr_d    = uc_write;
            wdata_d = uc_data_in;
            cnt_d   = '0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (uACK || (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          state_d = HOLD;
          if (!uACK) err_d = 1'b1;
          if (!wr_q) dout_d = uACK ? uDATA_R : {DATA_W{TIMEOUT_FILL}};
`ifdef UC_AUTOINC_EN
          addr_d = addr_q + ADDR_W'(1);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!stb_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign uADDR        = addr_q;
  assign uDATA_W      = wdata_q;
  assign uWRITE       = wr_q;
  assign uREQ         = req_q;
  assign uc_data_out  = dout_q;
  assign uc_data_oe   = ~uc_write;
  assign uc_interrupt = |pend_q;
  assign uc_not_ready = uc_strobe & ~uc_addr_set & (state_q != HOLD);

endmodule

// File: tb/tb_uc_bridge.sv
// Directed bench for uc_bridge: microcontroller pin model, bus slave, read-data scoreboard.
module tb_uc_bridge;

`ifdef UC_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] uc_data_in;
  logic [15:0] uc_data_out;
  logic        uc_data_oe;
  logic        uc_addr_set;
  logic        uc_write;
  logic        uc_strobe;
  logic        uc_not_ready;
  logic        uc_interrupt;
  logic [15:0] uADDR;
  logic [15:0] uDATA_W;
  logic [15:0] uDATA_R;
  logic        uWRITE;
  logic        uREQ;
  logic        uACK;
  logic [7:0]  uINTERRUPT;

  uc_bridge #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .NINT    (8),
    .TIMEOUT (255)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .uc_data_in   (uc_data_in),
    .uc_data_out  (uc_data_out),
    .uc_data_oe   (uc_data_oe),
    .uc_addr_set  (uc_addr_set),
    .uc_write     (uc_write),
    .uc_strobe    (uc_strobe),
    .uc_not_ready (uc_not_ready),
    .uc_interrupt (uc_interrupt),
    .uADDR        (uADDR),
    .uDATA_W      (uDATA_W),
    .uDATA_R      (uDATA_R),
    .uWRITE       (uWRITE),
    .uREQ         (uREQ),
    .uACK         (uACK),
    .uINTERRUPT   (uINTERRUPT)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_addr;
  logic [15:0] adr_at_req;

  // Bus slave: acks ack_delay clocks after uREQ is first seen (0 = never)
  int   ack_delay     = 0;
  int   req_clks      = 0;
  int   last_req_len  = 0;
  logic ack_was       = 1'b0;
  logic nr_at_ack     = 1'b0;
  logic nr_after_ack  = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic uc_acc(input logic aset, input logic wr, input logic [15:0] din,
                        input logic [7:0] irq_pulse);
    int n;
    logic [15:0] e;
    tick(1);
    uc_addr_set = aset;
    uc_write    = wr;
    uc_data_in  = din;
    uc_strobe   = 1'b1;
    uINTERRUPT  = uINTERRUPT | irq_pulse;
    if (!aset) begin
      #1;
      chk("nr_immediate", uc_not_ready, 1);
      n = 0;
      while (!uREQ && n < 10) begin
        tick(1);
        n++;
      end
      chk("req_latency", n, 3);
      adr_at_req = uADDR;
      chk("addr_at_req", adr_at_req, model_addr);
      n = 0;
      while (uc_not_ready && n < 400) begin
        tick(1);
        n++;
      end
      chk("nr_release", uc_not_ready, 0);
      if (AUTOINC) model_addr = model_addr + 16'd1;
    end else begin
      tick(4);
      if (wr) model_addr = din;
    end
    if (!wr) begin
      chk("data_oe", uc_data_oe, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data", uc_data_out, e);
      end else begin
        total++;
        bad++;
        $error("FAIL sb_underflow observed=%h expected=none", uc_data_out);
      end
    end
    uc_strobe  = 1'b0;
    uINTERRUPT = uINTERRUPT & ~irq_pulse;
    tick(4);
  endtask

  initial begin
    uACK    = 1'b0;
    uDATA_R = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (ack_was) nr_after_ack = uc_not_ready;
      ack_was = 1'b0;
      if (uREQ) begin
        req_clks++;
        if (ack_delay > 0 && req_clks == ack_delay) begin
          uACK      = 1'b1;
          ack_was   = 1'b1;
          nr_at_ack = uc_not_ready;
        end else begin
          uACK = 1'b0;
        end
      end else begin
        if (req_clks > 0) last_req_len = req_clks;
        req_clks = 0;
        uACK     = 1'b0;
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    uc_data_in  = 16'h0000;
    uc_addr_set = 1'b0;
    uc_write    = 1'b0;
    uc_strobe   = 1'b0;
    uINTERRUPT  = 8'h00;
    model_addr  = 16'h0000;
    #2;
    chk("rst_ureq", uREQ, 0);
    chk("rst_uaddr", uADDR, 0);
    chk("rst_dout", uc_data_out, 0);
    chk("rst_irq", uc_interrupt, 0);
    chk("rst_nr", uc_not_ready, 0);
    chk("rst_uwrite", uWRITE, 0);
    chk("rst_udataw", uDATA_W, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Address write then acknowledged data write
    uc_acc(1'b1, 1'b1, 16'h1234, 8'h00);
    chk("addr_write", uADDR, 16'h1234);
    ack_delay = 4;
    uc_acc(1'b0, 1'b1, 16'hBEEF, 8'h00);
    chk("wr_udataw", uDATA_W, 16'hBEEF);
    chk("wr_uwrite", uWRITE, 1);
    chk("wr_req_len", last_req_len, 4);
    chk("nr_at_ack", nr_at_ack, 1);
    chk("nr_after_ack", nr_after_ack, 0);
    chk("wr_uaddr", uADDR, model_addr);

    // Acknowledged data read
    ack_delay = 2;
    uDATA_R   = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    uc_acc(1'b0, 1'b0, 16'h0000, 8'h00);
    chk("rd_uwrite", uWRITE, 0);
    chk("rd_req_len", last_req_len, 2);
    chk("rd_udataw_held", uDATA_W, 16'h0000);

    // Timed-out read, then err reported once by status read
    ack_delay = 0;
    exp_q.push_back(16'hFFFF);
    uc_acc(1'b0, 1'b0, 16'h0000, 8'h00);
    chk("to_req_len", last_req_len, 255);
    exp_q.push_back(16'h8000);
    uc_acc(1'b1, 1'b0, 16'h0000, 8'h00);
    exp_q.push_back(16'h0000);
    uc_acc(1'b1, 1'b0, 16'h0000, 8'h00);

    // Interrupt latching and read-to-clear
    uINTERRUPT = 8'h09;
    tick(3);
    uINTERRUPT = 8'h00;
    tick(3);
    chk("irq_set", uc_interrupt, 1);
    exp_q.push_back(16'h0009);
    uc_acc(1'b1, 1'b0, 16'h0000, 8'h00);
    chk("irq_cleared", uc_interrupt, 0);
    uINTERRUPT = 8'h04;
    tick(3);
    uINTERRUPT = 8'h00;
    tick(3);
    exp_q.push_back(16'h0004);
    uc_acc(1'b1, 1'b0, 16'h0000, 8'h02);
    chk("irq_kept", uc_interrupt, 1);
    exp_q.push_back(16'h0002);
    uc_acc(1'b1, 1'b0, 16'h0000, 8'h00);
    chk("irq_final", uc_interrupt, 0);

    // Address wrap on consecutive data writes
    ack_delay = 1;
    uc_acc(1'b1, 1'b1, 16'hFFFF, 8'h00);
    chk("wrap_addr0", uADDR, 16'hFFFF);
    uc_acc(1'b0, 1'b1, 16'h1111, 8'h00);
    chk("wrap_addr1", uADDR, AUTOINC ? 16'h0000 : 16'hFFFF);
    uc_acc(1'b0, 1'b1, 16'h2222, 8'h00);
    chk("wrap_addr2", uADDR, model_addr);

    // Reset asserted in the middle of a bus cycle
    ack_delay = 0;
    tick(1);
    uc_addr_set = 1'b0;
    uc_write    = 1'b0;
    uc_strobe   = 1'b1;
    tick(5);
    chk("mid_req_high", uREQ, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_req_async", uREQ, 0);
    chk("mid_nr", uc_not_ready, 1);
    chk("mid_uaddr", uADDR, 0);
    model_addr = 16'h0000;
    uc_strobe  = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    ack_delay = 3;
    uc_acc(1'b0, 1'b1, 16'h4321, 8'h00);
    chk("post_rst_len", last_req_len, 3);
    chk("post_rst_data", uDATA_W, 16'h4321);
    chk("post_rst_addr", uADDR, model_addr);

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
